instr_mem_sync: RTL and testbench
=================================

// Module: instr_mem_sync
// PURPOSE
//  Parametrised, synchronous-read instruction memory for the MIPS fetch stage.
//  Sits between the PC register and IF/ID: adds a registered read, a stall hold,
//  a runtime program-load port, alignment/range fault detection and an optional
//  post-reset clear sequencer. Depth and width are set by parameters.
// PARAMETERS
//  DEPTH      64            number of instruction words (power of 2, 4..4096)
//  DATA_W     32            instruction word width
//  AW         $clog2(DEPTH) word-index width (derived, not overridden)
//  NOP_WORD   32'h00000000  word driven on fault and written by the clear sequence
//  CLR_ON_RST 1             1: sweep every entry to NOP_WORD after reset
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       synchronous, active-high reset
//  fetch_req  in   1       fetch request for pc this cycle
//  pc         in   32      byte address; word index = pc[AW+1:2]
//  stall      in   1       hold inst_out/inst_valid/fault; no new fetch accepted
//  inst_out   out  DATA_W  registered instruction
//  inst_valid out  1       inst_out holds a completed fetch
//  fault      out  1       last fetch was misaligned or out of range
//  load_en    in   1       write load_data at load_addr (word index)
//  load_addr  in   AW      load word index
//  load_data  in   DATA_W  load data
//  busy       out  1       clear sequence running; fetches and loads ignored
// BEHAVIOUR
//  Reset (reset=1 at a clk edge): inst_out=NOP_WORD, inst_valid=0, fault=0,
//   clr_ptr=0. State goes to CLEAR if CLR_ON_RST=1, otherwise RUN. busy=1 only in CLEAR.
//   Memory contents are not reset by reset itself.
//  FSM states:
//   CLEAR: write NOP_WORD to mem[clr_ptr] and increment clr_ptr each cycle.
//    When clr_ptr==DEPTH-1, go to RUN. CLEAR lasts exactly DEPTH cycles.
//    In CLEAR: inst_valid=0; fetch_req and load_en are ignored.
//   RUN: normal operation. There is no exit except reset.
//  Reset asserted in any state aborts the sweep: restart at clr_ptr=0.
//  Fetch (RUN, fetch_req=1, stall=0): one-cycle latency. At the next edge:
//   - If pc[1:0]!=0 or pc[31:AW+2]!=0: inst_out=NOP_WORD, fault=1, inst_valid=1.
//   - Otherwise: inst_out=mem[pc[AW+1:2]], fault=0, inst_valid=1.
//  fetch_req=0 with stall=0: inst_valid clears to 0 at the next edge.
//   inst_out and fault hold their values.
//  stall=1: inst_out, inst_valid and fault hold exactly. pc/fetch_req are ignored.
//   Loads still proceed.
//  Load (RUN, load_en=1): mem[load_addr] <= load_data at the edge. Independent of stall.
//  Load and fetch to the same index in the same cycle: write-first.
//   inst_out=load_data, fault=0.
//  Index wrap-around is never silent: an out-of-range pc always faults.
//  No combinational path from any input to any output.
//  Optional $readmemh preload in simulation only.
// TESTING
//  T1 reset, CLR_ON_RST=1, DEPTH=64 -> busy=1 for exactly 64 cycles.
//   Then every fetch returns 32'h00000000 with fault=0.
//  T2 load 0x3c010000@0 and 0x34240050@1. Fetch pc=0, then pc=4.
//   -> inst_out=0x3c010000 then 0x34240050, each one cycle after its request.
//  T3 fetch pc=0x6 -> fault=1, inst_out=NOP_WORD.
//   Fetch pc=0x100 with DEPTH=64 -> fault=1.
//  T4 fetch pc=4, then stall=1 for 3 cycles while pc changes to 8.
//   -> inst_out stays 0x34240050 with inst_valid=1.
//   After stall=0, the next fetch returns mem[2].
//  T5 load_en=1, load_addr=5, load_data=0x01244022, with a fetch of pc=0x14
//   in the same cycle -> inst_out=0x01244022.
//  T6 reset at clear-cycle 20 -> sweep restarts at 0; busy lasts 64 cycles after the reset edge.
//   Fetches and loads issued during busy have no effect.

Source files
------------

// File: rtl/instr_mem_sync.sv
// Synchronous-read instruction memory for the fetch stage: registered read with
// stall hold, runtime load port, alignment/range faults and a post-reset clear sweep.
module instr_mem_sync #(
    parameter int                 DEPTH      = 64,
    parameter int                 DATA_W     = 32,
    parameter logic [DATA_W-1:0]  NOP_WORD   = '0,
    parameter bit                 CLR_ON_RST = 1'b1,
    localparam int                AW         = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [31:0]       pc,
    input  logic              stall,
    output logic [DATA_W-1:0] inst_out,
    output logic              inst_valid,
    output logic              fault,
    input  logic              load_en,
    input  logic [AW-1:0]     load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              busy
);

    // state | meaning
    // CLEAR | sweeping NOP_WORD through every entry; fetches and loads ignored
    // RUN   | normal fetch/load operation; left only through reset
    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state;
    logic [AW-1:0]     clr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0]     idx;
    logic              bad_addr;
    logic [DATA_W-1:0] rd_data;

    // Write-first bypass so a same-cycle load to the fetched index is seen.
    always_comb begin
        idx      = pc[AW+1:2];
        bad_addr = (pc[1:0] != 2'b00) || (|pc[31:AW+2]);
        rd_data  = (load_en && (load_addr == idx)) ? load_data : mem[idx];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR)
                mem[clr_ptr] <= NOP_WORD;
            else if (load_en)
                mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= CLR_ON_RST ? CLEAR : RUN;
            busy       <= CLR_ON_RST;
            clr_ptr    <= '0;
            inst_out   <= NOP_WORD;
            inst_valid <= 1'b0;
            fault      <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    inst_valid <= 1'b0;
                    clr_ptr    <= clr_ptr + 1'b1;
                    if (clr_ptr == AW'(DEPTH - 1)) begin
                        state <= RUN;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    if (!stall) begin
                        if (fetch_req) begin
                            inst_valid <= 1'b1;
                            fault      <= bad_addr;
                            inst_out   <= bad_addr ? NOP_WORD : rd_data;
                        end else begin
                            inst_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= RUN;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_sync.sv
// Directed bench for instr_mem_sync (DEPTH=64): clear sweep, load/fetch,
// faults, stall hold, write-first bypass and reset during the sweep.
module tb_instr_mem_sync;

    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          fetch_req;
    logic [31:0]   pc;
    logic          stall;
    logic [31:0]   inst_out;
    logic          inst_valid;
    logic          fault;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;
    logic          busy;

    int checks = 0;
    int errors = 0;

    instr_mem_sync #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_req  (fetch_req),
        .pc         (pc),
        .stall      (stall),
        .inst_out   (inst_out),
        .inst_valid (inst_valid),
        .fault      (fault),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fetch_req = 1'b0; stall = 1'b0; load_en = 1'b0;
        pc = '0; load_addr = '0; load_data = '0;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [31:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] addr);
        fetch_req = 1'b1; pc = addr;
        tick();
        fetch_req = 1'b0;
    endtask

    // Counts cycles with busy high; a runaway counts as a failure via the length check.
    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            tick();
            n++;
            check_val("valid_in_clear", {31'b0, inst_valid}, 32'h0);
        end
    endtask

    int n;

    initial begin
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check_val("rst_inst", inst_out, 32'h0);
        check_val("rst_valid", {31'b0, inst_valid}, 32'h0);
        check_val("rst_fault", {31'b0, fault}, 32'h0);
        check_val("rst_busy", {31'b0, busy}, 32'h1);
        count_busy(n);
        check_val("busy_len", n, 64);

        // T1: cleared memory reads back as NOP
        fetch(32'h0);
        check_val("t1_inst0", inst_out, 32'h0);
        check_val("t1_valid", {31'b0, inst_valid}, 32'h1);
        check_val("t1_fault", {31'b0, fault}, 32'h0);
        fetch(32'hFC);
        check_val("t1_inst_last", inst_out, 32'h0);
        check_val("t1_fault_last", {31'b0, fault}, 32'h0);

        // T2: load then fetch, one-cycle latency
        load(6'd0, 32'h3c010000);
        load(6'd1, 32'h34240050);
        load(6'd2, 32'h00851020);
        fetch_req = 1'b1; pc = 32'h0;
        #2;
        check_val("t2_no_comb", {31'b0, inst_valid}, 32'h0);
        tick();
        fetch_req = 1'b0;
        check_val("t2_inst0", inst_out, 32'h3c010000);
        check_val("t2_valid0", {31'b0, inst_valid}, 32'h1);
        fetch(32'h4);
        check_val("t2_inst1", inst_out, 32'h34240050);
        tick();
        check_val("t2_idle_valid", {31'b0, inst_valid}, 32'h0);
        check_val("t2_idle_hold", inst_out, 32'h34240050);

        // T3: faults
        fetch(32'h6);
        check_val("t3_mis_fault", {31'b0, fault}, 32'h1);
        check_val("t3_mis_inst", inst_out, 32'h0);
        check_val("t3_mis_valid", {31'b0, inst_valid}, 32'h1);
        fetch(32'h4);
        check_val("t3_ok_fault", {31'b0, fault}, 32'h0);
        fetch(32'h100);
        check_val("t3_range_fault", {31'b0, fault}, 32'h1);
        check_val("t3_range_inst", inst_out, 32'h0);
        fetch(32'h8000_0000);
        check_val("t3_msb_fault", {31'b0, fault}, 32'h1);
        stall = 1'b1;
        tick();
        check_val("t3_stall_fault", {31'b0, fault}, 32'h1);
        stall = 1'b0;

        // T4: stall hold, loads proceed under stall
        fetch(32'h4);
        check_val("t4_pre", inst_out, 32'h34240050);
        stall = 1'b1; fetch_req = 1'b1; pc = 32'h8;
        load_en = 1'b1; load_addr = 6'd3; load_data = 32'h11111111;
        for (int i = 0; i < 3; i++) begin
            tick();
            load_en = 1'b0;
            check_val("t4_hold_inst", inst_out, 32'h34240050);
            check_val("t4_hold_valid", {31'b0, inst_valid}, 32'h1);
            check_val("t4_hold_fault", {31'b0, fault}, 32'h0);
        end
        stall = 1'b0;
        tick();
        fetch_req = 1'b0;
        check_val("t4_after", inst_out, 32'h00851020);
        fetch(32'hC);
        check_val("t4_stall_load", inst_out, 32'h11111111);

        // T5: write-first on same index
        load_en = 1'b1; load_addr = 6'd5; load_data = 32'h01244022;
        fetch(32'h14);
        load_en = 1'b0;
        check_val("t5_bypass", inst_out, 32'h01244022);
        check_val("t5_fault", {31'b0, fault}, 32'h0);
        fetch(32'h14);
        check_val("t5_stored", inst_out, 32'h01244022);

        // T6: reset partway through the sweep restarts it
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("t6_rst_inst", inst_out, 32'h0);
        check_val("t6_rst_valid", {31'b0, inst_valid}, 32'h0);
        for (int i = 0; i < 20; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("t6_busy", {31'b0, busy}, 32'h1);
        fetch_req = 1'b1; pc = 32'h0;
        load_en = 1'b1; load_addr = 6'd0; load_data = 32'hdeadbeef;
        count_busy(n);
        idle();
        check_val("t6_busy_len", n, 64);
        fetch(32'h0);
        check_val("t6_ignored_load", inst_out, 32'h0);
        fetch(32'h14);
        check_val("t6_swept", inst_out, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
